fft_peak_scan: RTL and testbench

- Downstream consumer of the FFT result buffers. On each FFT frame-done pulse, walks the selected channel's result RAM over AddrFFT_ADC.
- Converts each 28-bit complex bin to an approximate magnitude and streams the magnitudes out with a valid/ready handshake.
- Reports the peak bin once per frame.
- Runs in the clk_FFT domain, between the FFT core and the frame sender.

---
 rtl/fft_pkg.sv | 24 ++
 rtl/cplx_mag_approx.sv | 29 ++
 rtl/fft_peak_scan.sv | 176 +++++++++++++++++
 tb/tb_fft_peak_scan.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants and state encoding for the FFT result scanner.
package fft_pkg;

    localparam int N_BINS_DEF = 128;
    localparam int ADDR_W_DEF = 8;
    localparam int DW_DEF     = 14;
    localparam int MAG_W      = DW_DEF + 1;

    // Field positions inside one result word {re, im}
    localparam int RE_MSB = 27;
    localparam int RE_LSB = 14;
    localparam int IM_MSB = 13;
    localparam int IM_LSB = 0;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_WAIT = 3'd2,
        S_CALC = 3'd3,
        S_OUT  = 3'd4,
        S_DONE = 3'd5
    } scan_state_e;

endpackage

// File: rtl/cplx_mag_approx.sv
// Combinational magnitude estimate of a signed complex sample:
// max(|re|,|im|) + min(|re|,|im|)/2, truncating.
module cplx_mag_approx
    import fft_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int MW = MAG_W
) (
    input  logic signed [DW-1:0] re_i,
    input  logic signed [DW-1:0] im_i,
    output logic        [MW-1:0] mag_o
);

    logic [DW-1:0] abs_re;
    logic [DW-1:0] abs_im;
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;

    // Absolute values kept DW bits wide: the most negative input maps to its exact
    // unsigned magnitude, and the DW+1 bit sum cannot overflow.
    always_comb begin
        abs_re = re_i[DW-1] ? (~re_i + DW'(1)) : re_i;
        abs_im = im_i[DW-1] ? (~im_i + DW'(1)) : im_i;
        hi     = (abs_re > abs_im) ? abs_re : abs_im;
        lo     = (abs_re > abs_im) ? abs_im : abs_re;
        mag_o  = MW'(hi) + MW'(lo >> 1);
    end

endmodule

// File: rtl/fft_peak_scan.sv
// Walks one channel's FFT result RAM per frame, streams approximate bin
// magnitudes over valid/ready and reports the frame's peak bin.
//
// state | meaning
// IDLE  | waiting for dv_FFT
// ADDR  | present bin address, assert read enable of latched channel
// WAIT  | RD_LAT cycles of RAM latency, capture word on the last one
// CALC  | register magnitude, update running peak
// OUT   | offer magnitude downstream until accepted
// DONE  | one-cycle peak_valid pulse
module fft_peak_scan
    import fft_pkg::*;
#(
    parameter int N_BINS  = N_BINS_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DW      = DW_DEF,
    parameter int RD_LAT  = 2,
    parameter int SKIP_DC = 1
) (
    input  logic              clk_FFT,
    input  logic              rst_n,
    input  logic              dv_FFT,
    input  logic              ch_sel,
    output logic [ADDR_W-1:0] AddrFFT_ADC,
    output logic              ReadFFTEn_ADC1,
    output logic              ReadFFTEn_ADC2,
    input  logic [2*DW-1:0]   Data_send_FFT1,
    input  logic [2*DW-1:0]   Data_send_FFT2,
    output logic [DW:0]       mag_out,
    output logic [ADDR_W-1:0] mag_bin,
    output logic              mag_valid,
    input  logic              mag_ready,
    output logic [ADDR_W-1:0] peak_bin,
    output logic [DW:0]       peak_mag,
    output logic              peak_valid,
    output logic              busy,
    output logic              overrun
);

    localparam int WCW = 3;

    scan_state_e       state_q,    state_d;
    logic [ADDR_W-1:0] bin_q,      bin_d;
    logic [WCW-1:0]    wcnt_q,     wcnt_d;
    logic              ch_q,       ch_d;
    logic [2*DW-1:0]   data_q,     data_d;
    logic [DW:0]       mag_q,      mag_d;
    logic [DW:0]       run_mag_q,  run_mag_d;
    logic [ADDR_W-1:0] run_bin_q,  run_bin_d;
    logic [DW:0]       peak_mag_q, peak_mag_d;
    logic [ADDR_W-1:0] peak_bin_q, peak_bin_d;
    logic              overrun_q,  overrun_d;
    logic [DW:0]       mag_c;
    logic              rd_act;

    cplx_mag_approx #(.DW(DW), .MW(DW + 1)) u_mag (
        .re_i  ($signed(data_q[RE_MSB:RE_LSB])),
        .im_i  ($signed(data_q[IM_MSB:IM_LSB])),
        .mag_o (mag_c)
    );

    // State and datapath registers
    always_ff @(posedge clk_FFT or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            bin_q      <= '0;
            wcnt_q     <= '0;
            ch_q       <= 1'b0;
            data_q     <= '0;
            mag_q      <= '0;
            run_mag_q  <= '0;
            run_bin_q  <= '0;
            peak_mag_q <= '0;
            peak_bin_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            wcnt_q     <= wcnt_d;
            ch_q       <= ch_d;
            data_q     <= data_d;
            mag_q      <= mag_d;
            run_mag_q  <= run_mag_d;
            run_bin_q  <= run_bin_d;
            peak_mag_q <= peak_mag_d;
            peak_bin_q <= peak_bin_d;
            overrun_q  <= overrun_d;
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        wcnt_d     = wcnt_q;
        ch_d       = ch_q;
        data_d     = data_q;
        mag_d      = mag_q;
        run_mag_d  = run_mag_q;
        run_bin_d  = run_bin_q;
        peak_mag_d = peak_mag_q;
        peak_bin_d = peak_bin_q;
        overrun_d  = overrun_q;

        // A frame-done pulse outside IDLE (including DONE) is dropped and flagged
        if (dv_FFT) begin
            if (state_q == S_IDLE) begin
                ch_d      = ch_sel;
                bin_d     = '0;
                run_mag_d = '0;
                run_bin_d = '0;
                overrun_d = 1'b0;
                state_d   = S_ADDR;
            end else begin
                overrun_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: ;
            S_ADDR: begin
                wcnt_d  = WCW'(RD_LAT - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wcnt_q == '0) begin
                    data_d  = ch_q ? Data_send_FFT2 : Data_send_FFT1;
                    state_d = S_CALC;
                end else begin
                    wcnt_d = wcnt_q - WCW'(1);
                end
            end
            S_CALC: begin
                mag_d = mag_c;
                if ((mag_c > run_mag_q) && !((SKIP_DC != 0) && (bin_q == '0))) begin
                    run_mag_d = mag_c;
                    run_bin_d = bin_q;
                end
                state_d = S_OUT;
            end
            S_OUT: begin
                if (mag_ready) begin
                    if (bin_q == ADDR_W'(N_BINS - 1)) begin
                        // Publish one edge early so peak_* is already valid during the pulse
                        peak_mag_d = run_mag_q;
                        peak_bin_d = run_bin_q;
                        state_d    = S_DONE;
                    end else begin
                        bin_d   = bin_q + ADDR_W'(1);
                        state_d = S_ADDR;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs; the address simply follows the bin counter, which only moves on
    // the same edge that enters ADDR, so it holds outside ADDR/WAIT
    always_comb begin
        rd_act         = (state_q == S_ADDR) || (state_q == S_WAIT);
        AddrFFT_ADC    = bin_q;
        ReadFFTEn_ADC1 = rd_act && !ch_q;
        ReadFFTEn_ADC2 = rd_act && ch_q;
        mag_out        = mag_q;
        mag_bin        = bin_q;
        mag_valid      = (state_q == S_OUT);
        peak_bin       = peak_bin_q;
        peak_mag       = peak_mag_q;
        peak_valid     = (state_q == S_DONE);
        busy           = (state_q != S_IDLE);
        overrun        = overrun_q;
    end

endmodule

// File: tb/tb_fft_peak_scan.sv
// Testbench for fft_peak_scan: RAM models with RD_LAT latency, a negedge monitor
// that logs accepted beats, and a frame-level reference model.
module tb_fft_peak_scan;

    localparam int N_BINS  = 128;
    localparam int ADDR_W  = 8;
    localparam int DW      = 14;
    localparam int RD_LAT  = 2;
    localparam int SKIP_DC = 1;
    localparam int MW      = DW + 1;

    logic              clk_FFT   = 1'b0;
    logic              rst_n     = 1'b0;
    logic              dv_FFT    = 1'b0;
    logic              ch_sel    = 1'b0;
    logic              mag_ready = 1'b1;
    logic [ADDR_W-1:0] AddrFFT_ADC;
    logic              ReadFFTEn_ADC1, ReadFFTEn_ADC2;
    logic [2*DW-1:0]   Data_send_FFT1 = '0;
    logic [2*DW-1:0]   Data_send_FFT2 = '0;
    logic [MW-1:0]     mag_out;
    logic [ADDR_W-1:0] mag_bin;
    logic              mag_valid;
    logic [ADDR_W-1:0] peak_bin;
    logic [MW-1:0]     peak_mag;
    logic              peak_valid, busy, overrun;

    int n_tests = 0;
    int n_fail  = 0;

    logic [2*DW-1:0] ram1 [0:255];
    logic [2*DW-1:0] ram2 [0:255];
    logic [2*DW-1:0] p1 = '0;
    logic [2*DW-1:0] p2 = '0;

    int cyc = 0;
    int dv_cyc = 0;
    int got_bin[$];
    int got_mag[$];
    int got_cyc[$];
    int pk_cnt = 0, pk_cyc = 0, pk_bin_s = 0, pk_mag_s = 0;
    int en1_cnt = 0, en2_cnt = 0;

    int exp_m [N_BINS];
    int exp_pk_bin, exp_pk_mag;

    fft_peak_scan #(
        .N_BINS(N_BINS), .ADDR_W(ADDR_W), .DW(DW), .RD_LAT(RD_LAT), .SKIP_DC(SKIP_DC)
    ) dut (
        .clk_FFT(clk_FFT), .rst_n(rst_n), .dv_FFT(dv_FFT), .ch_sel(ch_sel),
        .AddrFFT_ADC(AddrFFT_ADC), .ReadFFTEn_ADC1(ReadFFTEn_ADC1), .ReadFFTEn_ADC2(ReadFFTEn_ADC2),
        .Data_send_FFT1(Data_send_FFT1), .Data_send_FFT2(Data_send_FFT2),
        .mag_out(mag_out), .mag_bin(mag_bin), .mag_valid(mag_valid), .mag_ready(mag_ready),
        .peak_bin(peak_bin), .peak_mag(peak_mag), .peak_valid(peak_valid),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk_FFT = ~clk_FFT;

    always @(posedge clk_FFT) cyc <= cyc + 1;

    // Two-stage read pipeline per RAM: address registered when enabled, then output register
    always @(posedge clk_FFT) begin
        if (ReadFFTEn_ADC1) p1 <= ram1[AddrFFT_ADC];
        if (ReadFFTEn_ADC2) p2 <= ram2[AddrFFT_ADC];
        Data_send_FFT1 <= p1;
        Data_send_FFT2 <= p2;
    end

    always @(negedge clk_FFT) begin
        if (mag_valid && mag_ready) begin
            got_bin.push_back(int'(mag_bin));
            got_mag.push_back(int'(mag_out));
            got_cyc.push_back(cyc);
        end
        if (peak_valid) begin
            pk_cnt++;
            pk_cyc   = cyc;
            pk_bin_s = int'(peak_bin);
            pk_mag_s = int'(peak_mag);
        end
        if (ReadFFTEn_ADC1) en1_cnt++;
        if (ReadFFTEn_ADC2) en2_cnt++;
    end

    function automatic int ref_mag(logic [2*DW-1:0] w);
        int re, im, a, b;
        re = int'($signed(w[27:14]));
        im = int'($signed(w[13:0]));
        a  = (re < 0) ? -re : re;
        b  = (im < 0) ? -im : im;
        return (a > b) ? a + b / 2 : b + a / 2;
    endfunction

    function automatic void build_model(bit ch);
        exp_pk_bin = 0;
        exp_pk_mag = 0;
        for (int k = 0; k < N_BINS; k++) begin
            exp_m[k] = ref_mag(ch ? ram2[k] : ram1[k]);
            if (!(SKIP_DC != 0 && k == 0) && exp_m[k] > exp_pk_mag) begin
                exp_pk_mag = exp_m[k];
                exp_pk_bin = k;
            end
        end
    endfunction

    task automatic clear_mon();
        got_bin.delete();
        got_mag.delete();
        got_cyc.delete();
        pk_cnt  = 0;
        en1_cnt = 0;
        en2_cnt = 0;
    endtask

    task automatic fill_random(input bit ch);
        logic [2*DW-1:0] w;
        for (int k = 0; k < 256; k++) begin
            w = 28'($urandom);
            if ($urandom_range(0, 7) == 0) w[27:14] = 14'h2000;
            if ($urandom_range(0, 7) == 0) w[13:0]  = 14'h2000;
            if (ch) ram2[k] = w; else ram1[k] = w;
        end
    endtask

    task automatic pulse_dv(input bit ch);
        @(posedge clk_FFT); #1;
        dv_FFT = 1'b1;
        ch_sel = ch;
        @(posedge clk_FFT); #1;
        dv_FFT = 1'b0;
        ch_sel = 1'($urandom);
        dv_cyc = cyc;
    endtask

    task automatic wait_peak(input int mode, input int budget);
        int t = 0;
        while (pk_cnt == 0 && t < budget) begin
            @(posedge clk_FFT); #1;
            mag_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 7);
            t++;
        end
        mag_ready = 1'b1;
        n_tests++;
        if (pk_cnt == 0) begin
            n_fail++;
            $display("FAIL frame_timeout: no peak_valid after %0d cycles (required within %0d)", t, budget);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #23;
        n_tests++;
        if ({busy, mag_valid, peak_valid, overrun, ReadFFTEn_ADC1, ReadFFTEn_ADC2} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: busy=%b valid=%b pv=%b ovr=%b en1=%b en2=%b (required all 0)",
                     busy, mag_valid, peak_valid, overrun, ReadFFTEn_ADC1, ReadFFTEn_ADC2);
        end
        n_tests++;
        if (mag_out !== '0 || mag_bin !== '0 || peak_bin !== '0 || peak_mag !== '0 || AddrFFT_ADC !== '0) begin
            n_fail++;
            $display("FAIL reset_data: mag=%0d bin=%0d pbin=%0d pmag=%0d addr=%0d (required 0)",
                     mag_out, mag_bin, peak_bin, peak_mag, AddrFFT_ADC);
        end
        @(negedge clk_FFT);
        rst_n = 1'b1;
    endtask

    task automatic test_ramp();
        int errs = 0;
        int bad_gap = 0;
        for (int k = 0; k < 256; k++) begin
            ram1[k] = {14'(k), 14'd0};
            ram2[k] = 28'($urandom);
        end
        build_model(0);
        clear_mon();
        pulse_dv(0);
        wait_peak(0, 2000);
        foreach (got_bin[i]) if (got_bin[i] != i || got_mag[i] != i) errs++;
        n_tests++;
        if (got_bin.size() != N_BINS || errs != 0) begin
            n_fail++;
            $display("FAIL ramp_stream: %0d beats, %0d wrong (required %0d beats, 0 wrong)", got_bin.size(), errs, N_BINS);
        end
        n_tests++;
        if (pk_bin_s != 127 || pk_mag_s != 127) begin
            n_fail++;
            $display("FAIL ramp_peak: bin=%0d mag=%0d (required 127/127)", pk_bin_s, pk_mag_s);
        end
        n_tests++;
        if (en2_cnt != 0 || en1_cnt != N_BINS * (RD_LAT + 1)) begin
            n_fail++;
            $display("FAIL ramp_enables: en1 cycles=%0d en2 cycles=%0d (required %0d/0)", en1_cnt, en2_cnt, N_BINS * (RD_LAT + 1));
        end
        n_tests++;
        if (got_cyc.size() == 0 || got_cyc[0] - dv_cyc != RD_LAT + 2) begin
            n_fail++;
            $display("FAIL ramp_first_latency: got %0d cycles after dv edge (required %0d)",
                     (got_cyc.size() == 0) ? -1 : got_cyc[0] - dv_cyc, RD_LAT + 2);
        end
        for (int i = 1; i < got_cyc.size(); i++) if (got_cyc[i] - got_cyc[i-1] != RD_LAT + 3) bad_gap++;
        n_tests++;
        if (bad_gap != 0) begin
            n_fail++;
            $display("FAIL ramp_bin_period: %0d gaps differ (required all %0d cycles)", bad_gap, RD_LAT + 3);
        end
        n_tests++;
        if (pk_cyc - dv_cyc != N_BINS * (RD_LAT + 3)) begin
            n_fail++;
            $display("FAIL ramp_peak_latency: %0d (required %0d)", pk_cyc - dv_cyc, N_BINS * (RD_LAT + 3));
        end
    endtask

    task automatic test_extremes();
        for (int k = 0; k < 256; k++) ram1[k] = '0;
        ram1[5] = {14'h2000, 14'h2000};
        clear_mon();
        pulse_dv(0);
        wait_peak(0, 2000);
        n_tests++;
        if (got_mag.size() != N_BINS || got_mag[5] != 12288 || got_bin[5] != 5) begin
            n_fail++;
            $display("FAIL extreme_mag: beats=%0d mag[5]=%0d (required %0d beats, 12288)",
                     got_mag.size(), (got_mag.size() > 5) ? got_mag[5] : -1, N_BINS);
        end
        n_tests++;
        if (pk_bin_s != 5 || pk_mag_s != 12288) begin
            n_fail++;
            $display("FAIL extreme_peak: bin=%0d mag=%0d (required 5/12288)", pk_bin_s, pk_mag_s);
        end
    endtask

    task automatic test_dc_tie();
        logic signed [13:0] neg300;
        neg300 = -14'sd300;
        for (int k = 0; k < 256; k++) begin
            ram2[k] = '0;
            ram1[k] = 28'($urandom);
        end
        ram2[0]  = {14'd4000, 14'd0};
        ram2[10] = {14'd0, 14'd300};
        ram2[20] = {neg300, 14'd0};
        clear_mon();
        pulse_dv(1);
        wait_peak(0, 2000);
        n_tests++;
        if (pk_bin_s != 10 || pk_mag_s != 300) begin
            n_fail++;
            $display("FAIL dc_tie_peak: bin=%0d mag=%0d (required 10/300)", pk_bin_s, pk_mag_s);
        end
        n_tests++;
        if (got_mag.size() != N_BINS || got_mag[0] != 4000 || got_mag[20] != 300) begin
            n_fail++;
            $display("FAIL dc_tie_stream: beats=%0d (required %0d with bin0=4000 bin20=300)", got_mag.size(), N_BINS);
        end
        n_tests++;
        if (en1_cnt != 0 || en2_cnt == 0) begin
            n_fail++;
            $display("FAIL dc_tie_enables: en1=%0d en2=%0d (required 0 / nonzero)", en1_cnt, en2_cnt);
        end
    endtask

    task automatic test_random();
        bit ch;
        int errs;
        for (int f = 0; f < 3; f++) begin
            ch = 1'($urandom);
            fill_random(ch);
            fill_random(!ch);
            build_model(ch);
            clear_mon();
            pulse_dv(ch);
            wait_peak(1, 4000);
            errs = 0;
            foreach (got_bin[i]) if (got_bin[i] != i || got_mag[i] != exp_m[i]) errs++;
            n_tests++;
            if (got_bin.size() != N_BINS || errs != 0) begin
                n_fail++;
                $display("FAIL random_stream[%0d]: %0d beats, %0d wrong (required %0d, 0)", f, got_bin.size(), errs, N_BINS);
            end
            n_tests++;
            if (pk_bin_s != exp_pk_bin || pk_mag_s != exp_pk_mag || int'(peak_bin) != exp_pk_bin) begin
                n_fail++;
                $display("FAIL random_peak[%0d]: bin=%0d mag=%0d (required %0d/%0d)", f, pk_bin_s, pk_mag_s, exp_pk_bin, exp_pk_mag);
            end
            n_tests++;
            if ((ch ? en1_cnt : en2_cnt) != 0) begin
                n_fail++;
                $display("FAIL random_enables[%0d]: other channel enabled %0d cycles (required 0)", f, ch ? en1_cnt : en2_cnt);
            end
        end
    endtask

    task automatic test_backpressure();
        int t = 0;
        int bad = 0;
        int errs = 0;
        logic [MW-1:0] snap;
        fill_random(0);
        build_model(0);
        clear_mon();
        pulse_dv(0);
        while (!(mag_valid && int'(mag_bin) == 3) && t < 200) begin
            @(posedge clk_FFT); #1;
            t++;
        end
        mag_ready = 1'b0;
        snap = mag_out;
        repeat (50) begin
            @(negedge clk_FFT);
            if (mag_valid !== 1'b1 || int'(mag_bin) != 3 || mag_out !== snap || ReadFFTEn_ADC1 || ReadFFTEn_ADC2) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL backpressure_hold: %0d bad cycles of 50 (required 0)", bad);
        end
        n_tests++;
        if (int'(snap) != exp_m[3]) begin
            n_fail++;
            $display("FAIL backpressure_value: mag=%0d (required %0d)", snap, exp_m[3]);
        end
        @(posedge clk_FFT); #1;
        mag_ready = 1'b1;
        wait_peak(0, 2000);
        foreach (got_bin[i]) if (got_bin[i] != i || got_mag[i] != exp_m[i]) errs++;
        n_tests++;
        if (got_bin.size() != N_BINS || errs != 0) begin
            n_fail++;
            $display("FAIL backpressure_stream: %0d beats, %0d wrong (required %0d, 0)", got_bin.size(), errs, N_BINS);
        end
    endtask

    task automatic test_dv_in_done();
        int t = 0;
        fill_random(1);
        clear_mon();
        pulse_dv(1);
        while (!peak_valid && t < 2000) begin
            @(posedge clk_FFT); #1;
            t++;
        end
        dv_FFT = 1'b1;
        @(posedge clk_FFT); #1;
        dv_FFT = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL dv_in_done: busy=%b overrun=%b (required 0/1)", busy, overrun);
        end
    endtask

    task automatic test_overrun();
        int errs = 0;
        fill_random(0);
        build_model(0);
        clear_mon();
        pulse_dv(0);
        n_tests++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_cleared_by_dv: overrun=%b (required 0)", overrun);
        end
        repeat (100) begin @(posedge clk_FFT); #1; end
        dv_FFT = 1'b1;
        @(posedge clk_FFT); #1;
        dv_FFT = 1'b0;
        n_tests++;
        if (overrun !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_set: overrun=%b busy=%b (required 1/1)", overrun, busy);
        end
        wait_peak(0, 2000);
        repeat (20) begin @(posedge clk_FFT); #1; end
        foreach (got_bin[i]) if (got_bin[i] != i || got_mag[i] != exp_m[i]) errs++;
        n_tests++;
        if (got_bin.size() != N_BINS || errs != 0 || pk_cnt != 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_frame: beats=%0d wrong=%0d peaks=%0d busy=%b (required %0d,0,1,0)",
                     got_bin.size(), errs, pk_cnt, busy, N_BINS);
        end
        clear_mon();
        pulse_dv(0);
        n_tests++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_clear: overrun=%b (required 0)", overrun);
        end
        wait_peak(0, 2000);
    endtask

    task automatic test_reset_midscan();
        int t = 0;
        int errs = 0;
        fill_random(0);
        clear_mon();
        pulse_dv(0);
        while (!(mag_valid && int'(mag_bin) == 60) && t < 2000) begin
            @(posedge clk_FFT); #1;
            t++;
        end
        n_tests++;
        if (!(mag_valid && int'(mag_bin) == 60)) begin
            n_fail++;
            $display("FAIL reset_mid_reach: bin=%0d valid=%b (required 60/1)", mag_bin, mag_valid);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({busy, mag_valid, ReadFFTEn_ADC1, ReadFFTEn_ADC2, peak_valid} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_mid_flags: busy=%b valid=%b en1=%b en2=%b (required 0)",
                     busy, mag_valid, ReadFFTEn_ADC1, ReadFFTEn_ADC2);
        end
        n_tests++;
        if (peak_bin !== '0 || peak_mag !== '0 || mag_out !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_data: pbin=%0d pmag=%0d mag=%0d (required 0)", peak_bin, peak_mag, mag_out);
        end
        @(negedge clk_FFT);
        rst_n = 1'b1;
        fill_random(0);
        build_model(0);
        clear_mon();
        pulse_dv(0);
        wait_peak(0, 2000);
        foreach (got_bin[i]) if (got_bin[i] != i || got_mag[i] != exp_m[i]) errs++;
        n_tests++;
        if (got_bin.size() != N_BINS || errs != 0 || pk_bin_s != exp_pk_bin || pk_mag_s != exp_pk_mag) begin
            n_fail++;
            $display("FAIL reset_mid_rescan: beats=%0d wrong=%0d peak=%0d/%0d (required %0d,0,%0d/%0d)",
                     got_bin.size(), errs, pk_bin_s, pk_mag_s, N_BINS, exp_pk_bin, exp_pk_mag);
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_extremes();
        test_dc_tie();
        test_random();
        test_backpressure();
        test_dv_in_done();
        test_overrun();
        test_reset_midscan();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
